// File: rtl/led_rate_pkg.sv
// rtl/led_rate_pkg.sv - shared constants, press FSM encoding and rate table helpers
package led_rate_pkg;

    localparam int PERIOD_W = 26;
    localparam int SEL_W    = 2;

    localparam int DEF_P0_CYCLES       = 27000000;
    localparam int DEF_P1_CYCLES       = 13500000;
    localparam int DEF_P2_CYCLES       = 2700000;
    localparam int DEF_DEBOUNCE_CYCLES = 270000;
    localparam int DEF_LONG_CYCLES     = 27000000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } press_state_t;

    // Index 3 is unused by the rotation but must still resolve to the slow rate.
    function automatic logic [PERIOD_W-1:0] period_m1(input logic [SEL_W-1:0] sel,
                                                      input int p0, input int p1, input int p2);
        int p;
        case (sel)
            2'd1:    p = p1;
            2'd2:    p = p2;
            default: p = p0;
        endcase
        return PERIOD_W'(p - 1);
    endfunction

    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
        return (sel >= 2'd2) ? 2'd0 : sel + 2'd1;
    endfunction

    function automatic logic period_ok(input int p);
        return (p >= 2) && (p <= (1 << PERIOD_W));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser and debouncer with press/release strobes
module btn_debounce
    import led_rate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1        <= 1'b1;
            sync_2        <= 1'b1;
            level         <= 1'b1;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_1        <= btn_n;
            sync_2        <= sync_1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level         <= sync_2;
                cnt           <= '0;
                press_pulse   <= ~sync_2;
                release_pulse <= sync_2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_rate_ctrl.sv
// rtl/led_rate_ctrl.sv - button-driven LED tick rate selector with pause/resume
module led_rate_ctrl
    import led_rate_pkg::*;
#(
    parameter int P0_CYCLES       = DEF_P0_CYCLES,
    parameter int P1_CYCLES       = DEF_P1_CYCLES,
    parameter int P2_CYCLES       = DEF_P2_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                iBtnN,
    output logic                oTick,
    output logic [SEL_W-1:0]    oSel,
    output logic                oRun,
    output logic [PERIOD_W-1:0] oPeriod
);

    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    if (!period_ok(P0_CYCLES) || !period_ok(P1_CYCLES) || !period_ok(P2_CYCLES)) begin : g_bad_period
        $error("led_rate_ctrl: period parameters must lie in 2..2**26");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("led_rate_ctrl: LONG_CYCLES must be at least 1");
    end

    logic db_level;
    logic press_pulse;
    logic release_pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk          (CLK),
        .reset        (RESET),
        .btn_n        (iBtnN),
        .level        (db_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    press_state_t        state_q;
    press_state_t        state_d;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                short_evt;
    logic                long_evt;
    logic                short_q;
    logic                long_q;
    logic [SEL_W-1:0]    sel_q;
    logic                run_q;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] per_m1;
    logic                terminal;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        short_evt = 1'b0;
        long_evt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_pulse) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (release_pulse) begin
                    state_d   = ST_IDLE;
                    short_evt = 1'b1;
                end else if (!db_level && hold_cnt == HOLD_MAX) begin
                    state_d  = ST_LONG_HELD;
                    long_evt = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (release_pulse) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hold time is measured only while the debounced level says pressed.
    always_ff @(posedge CLK) begin
        if (RESET || state_q != ST_PRESSED) begin
            hold_cnt <= '0;
        end else if (!db_level && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign per_m1   = period_m1(sel_q, P0_CYCLES, P1_CYCLES, P2_CYCLES);
    assign terminal = (cnt == per_m1);

    // Press events are registered once, so rate and run react one edge after the FSM.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            sel_q   <= '0;
            run_q   <= 1'b1;
            cnt     <= '0;
        end else begin
            short_q <= short_evt;
            long_q  <= long_evt;
            if (long_q) begin
                run_q <= ~run_q;
            end
            if (short_q) begin
                sel_q <= next_sel(sel_q);
                cnt   <= '0;
            end else if (run_q) begin
                cnt <= terminal ? '0 : cnt + PERIOD_W'(1);
            end
        end
    end

    // A rate change in the same cycle as the terminal count swallows that tick.
    assign oTick   = run_q && terminal && !short_q;
    assign oSel    = sel_q;
    assign oRun    = run_q;
    assign oPeriod = per_m1;

endmodule

// File: tb/tb_led_rate_ctrl.sv
// tb/tb_led_rate_ctrl.sv - scoreboard bench for led_rate_ctrl with short parameters
module tb_led_rate_ctrl;

    localparam int P0 = 10;
    localparam int P1 = 5;
    localparam int P2 = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        iBtnN = 1'b1;
    logic        oTick;
    logic [1:0]  oSel;
    logic        oRun;
    logic [25:0] oPeriod;

    led_rate_ctrl #(
        .P0_CYCLES      (P0),
        .P1_CYCLES      (P1),
        .P2_CYCLES      (P2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .iBtnN  (iBtnN),
        .oTick  (oTick),
        .oSel   (oSel),
        .oRun   (oRun),
        .oPeriod(oPeriod)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
    } tick_t;

    tick_t      exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;

    int         sch_a;
    int         sch_v0;
    int         sch_p;
    int         pushed_to;
    logic [1:0] sch_sel;
    bit         sch_run;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int exp_period(input logic [1:0] s);
        case (s)
            2'd1:    return P1 - 1;
            2'd2:    return P2 - 1;
            default: return P0 - 1;
        endcase
    endfunction

    always @(negedge CLK) begin : monitor
        tick_t e;
        if (mon_en && !RESET) begin
            if (oTick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_tick: tick at cyc %0d sel %0d, required no tick", cyc, oSel);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.sel != oSel || int'(oPeriod) != exp_period(e.sel)) begin
                        fails++;
                        $display("FAIL tick: got cyc %0d sel %0d period %0d, required cyc %0d sel %0d period %0d",
                                 cyc, oSel, oPeriod, e.cyc, e.sel, exp_period(e.sel));
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                fails++;
                $display("FAIL missed_tick: no tick at cyc %0d, required tick at cyc %0d", cyc, e.cyc);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Queue every tick the current schedule predicts up to cycle 'to'.
    task automatic push_ticks(input int to);
        int t;
        if (sch_run) begin
            t = sch_a + sch_p - 1 - sch_v0;
            while (t <= pushed_to) t += sch_p;
            while (t <= to) begin
                exp_q.push_back('{cyc: t, sel: sch_sel});
                t += sch_p;
            end
        end
        if (to > pushed_to) pushed_to = to;
    endtask

    task automatic run_to(input int target);
        push_ticks(target);
        while (cyc < target) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_sched(input int a, input int v0, input int p, input logic [1:0] s, input bit r);
        sch_a   = a;
        sch_v0  = v0;
        sch_p   = p;
        sch_sel = s;
        sch_run = r;
    endtask

    // Release at r: release strobe r+6, FSM idle r+7 (tick masked), new rate from edge r+8.
    task automatic short_press(input logic [1:0] new_sel, input int new_p);
        int c;
        int r;
        c = cyc;
        iBtnN = 1'b0;
        run_to(c + 10);
        r = cyc;
        iBtnN = 1'b1;
        run_to(r + 6);
        pushed_to = r + 7;
        set_sched(r + 8, 0, new_p, new_sel, 1'b1);
        run_to(r + 8);
        check("sel_after_short", int'(oSel), int'(new_sel));
        check("period_after_short", int'(oPeriod), new_p - 1);
    endtask

    // Press at c: press strobe c+6, PRESSED c+7, LONG_HELD c+27, run toggles at edge c+28.
    task automatic long_start(output int c);
        c = cyc;
        iBtnN = 1'b0;
        run_to(c + 27);
        if (sch_run) begin
            sch_v0  = (sch_v0 + (c + 28) - sch_a) % sch_p;
            sch_run = 1'b0;
        end else begin
            sch_run = 1'b1;
        end
        sch_a = c + 28;
        run_to(c + 28);
        check("run_after_long", int'(oRun), int'(sch_run));
    endtask

    task automatic long_press();
        int c;
        long_start(c);
        run_to(c + 30);
        iBtnN = 1'b1;
        run_to(c + 40);
        check("run_after_long_release", int'(oRun), int'(sch_run));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c;
        int t;
        logic [1:0] sel_before;

        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        set_sched(cyc, 0, P0, 2'd0, 1'b1);
        pushed_to = cyc;
        mon_en = 1'b1;
        check("reset_sel", int'(oSel), 0);
        check("reset_run", int'(oRun), 1);
        check("reset_period", int'(oPeriod), P0 - 1);
        check("reset_tick", int'(oTick), 0);
        run_to(cyc + 40);

        c = cyc;
        iBtnN = 1'b0;
        run_to(c + 3);
        iBtnN = 1'b1;
        run_to(c + 20);
        check("glitch_sel", int'(oSel), 0);

        short_press(2'd1, P1);
        run_to(cyc + 20);
        short_press(2'd2, P2);
        run_to(cyc + 12);
        short_press(2'd0, P0);
        run_to(cyc + 25);

        t = sch_a + sch_p - 1 - sch_v0;
        while (t < cyc + 20) t += sch_p;
        run_to(t - 17);
        short_press(2'd1, P1);
        run_to(cyc + 20);

        sel_before = oSel;
        long_press();
        check("paused_run", int'(oRun), 0);
        run_to(cyc + 30);
        long_press();
        check("resumed_run", int'(oRun), 1);
        check("sel_kept_over_long", int'(oSel), int'(sel_before));
        run_to(cyc + 30);

        long_start(c);
        run_to(c + 30);
        check("run_before_reset", int'(oRun), 0);
        run_to(c + 32);
        RESET = 1'b1;
        run_to(c + 33);
        check("midreset_sel", int'(oSel), 0);
        check("midreset_run", int'(oRun), 1);
        check("midreset_tick", int'(oTick), 0);
        check("midreset_period", int'(oPeriod), P0 - 1);
        run_to(c + 34);
        RESET = 1'b0;
        set_sched(c + 34, 0, P0, 2'd0, 1'b1);
        pushed_to = c + 34;
        run_to(c + 35);
        iBtnN = 1'b1;
        run_to(c + 60);
        check("post_reset_run", int'(oRun), 1);
        check("post_reset_sel", int'(oSel), 0);
        run_to(cyc + 15);

        @(negedge CLK);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/led_rate_ctrl.md
LED_RATE_CTRL -- requirements
Module: led_rate_ctrl

Interface
REQ-001 SHALL have parameter P0_CYCLES, default 27000000; slow tick period in clock cycles (1 s at 27 MHz).
REQ-002 SHALL have parameter P1_CYCLES, default 13500000; medium tick period (0.5 s).
REQ-003 SHALL have parameter P2_CYCLES, default 2700000; fast tick period (0.1 s).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 270000; stable-input time (10 ms) required to accept a button level.
REQ-005 SHALL have parameter LONG_CYCLES, default 27000000; debounced hold time (1 s) that classifies a press as long.
REQ-006 SHALL have port CLK, input, 1: the single clock; all logic on the rising edge.
REQ-007 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port iBtnN, input, 1: raw asynchronous push-button, low = pressed.
REQ-009 SHALL have port oTick, output, 1: one-cycle strobe at the selected rate, consumed by the LED pattern counter.
REQ-010 SHALL have port oSel, output, 2: current rate index (0 slow, 1 medium, 2 fast).
REQ-011 SHALL have port oRun, output, 1: 1 = ticking, 0 = paused.
REQ-012 SHALL have port oPeriod, output, 26: active period minus 1, for status display.

Function
REQ-013 SHALL synchronise iBtnN through two flops before any other use.
REQ-014 SHALL update the debounced level only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the debounce counter.
REQ-015 SHALL run a press FSM with states IDLE, PRESSED, LONG_HELD: IDLE->PRESSED on debounced press; PRESSED->IDLE on debounced release; PRESSED->LONG_HELD when the hold count reaches LONG_CYCLES; LONG_HELD->IDLE on debounced release.
REQ-016 SHALL treat a PRESSED->IDLE transition as a short press: oSel advances 0->1->2->0 on the following edge.
REQ-017 SHALL treat entry into LONG_HELD as a long press: oRun toggles once on the following edge, with no sel change on release.
REQ-018 SHALL count a 26-bit tick counter 0..period-1 while oRun=1, with period selected by oSel; oSel=3 SHALL select P0_CYCLES.
REQ-019 SHALL assert oTick for exactly one cycle when the counter equals period-1 and oRun=1, wrapping the counter to 0 on the same edge.
REQ-020 SHALL clear the counter on any oSel change; if a sel change and a terminal count coincide, the sel change wins and no tick is emitted.
REQ-021 SHALL hold the counter value while oRun=0 and resume from that value when oRun returns to 1.
REQ-022 SHALL drive oPeriod combinationally from oSel as the selected period minus 1.
REQ-023 SHALL guarantee every period parameter is between 2 and 2^26 inclusive; violations are a static error.

Reset
REQ-024 SHALL, while RESET=1 at a clock edge, set oSel=0, oRun=1, oTick=0, counter=0, FSM=IDLE, debounce counter=0, synchroniser and debounced level = released (1).
REQ-025 SHALL discard any press in progress when RESET is asserted mid-operation; after release, a press already held requires a full debounce before it is recognised.

Structure
REQ-026 SHALL place the default period constants, the FSM state encoding and the sel-to-period table width in shared package led_rate_pkg.
REQ-027 SHALL implement synchroniser plus debouncer as sub-module btn_debounce, with outputs debounced level and one-cycle press and release pulses.

Verification (P0=10, P1=5, P2=2, DEBOUNCE=4, LONG=20)
REQ-028 SHALL check that after reset with no button, oTick pulses every 10 cycles, oSel=0, oRun=1, oPeriod=9.
REQ-029 SHALL check that a 3-cycle low glitch on iBtnN produces no sel change, while a 10-cycle press produces oSel 0->1 and oTick spacing 5.
REQ-030 SHALL check that three clean short presses wrap oSel 0->1->2->0, with counter restarted at each change.
REQ-031 SHALL check that a 30-cycle press toggles oRun to 0 once, oTick stays low and the counter is frozen, and a second long press resumes from the frozen value.
REQ-032 SHALL check that a short-press release timed to land on the terminal-count cycle yields no tick and a counter of 0 in the new rate.
REQ-033 SHALL check that RESET pulsed during LONG_HELD returns all outputs to reset values with no toggle on the subsequent release.
